// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two shift clients and the shifter arbiter.
// Both requester channels and the result channel use valid/ready handshakes.
interface shift_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_din;
  logic [2:0] req0_shamt;
  logic       req0_lr;
  logic       req0_al;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_din;
  logic [2:0] req1_shamt;
  logic       req1_lr;
  logic       req1_al;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_dout;
  logic       rsp_id;

  modport master (
    output req0_valid, req0_din, req0_shamt,
    output req0_lr, req0_al,
    input  req0_ready,
    output req1_valid, req1_din, req1_shamt,
    output req1_lr, req1_al,
    input  req1_ready,
    input  rsp_valid, rsp_dout, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_din, req0_shamt,
    input  req0_lr, req0_al,
    output req0_ready,
    input  req1_valid, req1_din, req1_shamt,
    input  req1_lr, req1_al,
    output req1_ready,
    output rsp_valid, rsp_dout, rsp_id,
    input  rsp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding one shared 8-bit barrel shifter.
// SHIFT_ARB_CNT_EN enables saturating per-requester grant counters.
module shift_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  shift_arbiter_if.slave bus,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic       last_grant;
  logic       slot_free;
  logic       gnt0, gnt1;
  logic       acc0, acc1, acc;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       lr, al;
  logic [7:0] shres;
  logic [7:0] dout_q;
  logic       id_q;

  always_comb begin
    slot_free = (state == EMPTY) || bus.rsp_ready;
    // under contention the requester that did not win last time goes
    gnt0 = bus.req0_valid &&
           (!bus.req1_valid || last_grant);
    gnt1 = bus.req1_valid &&
           (!bus.req0_valid || !last_grant);
  end

  assign bus.req0_ready = gnt0 && slot_free && !rst;
  assign bus.req1_ready = gnt1 && slot_free && !rst;

  assign acc0 = bus.req0_valid && bus.req0_ready;
  assign acc1 = bus.req1_valid && bus.req1_ready;
  assign acc  = acc0 || acc1;

  assign din   = gnt1 ? bus.req1_din   : bus.req0_din;
  assign shamt = gnt1 ? bus.req1_shamt : bus.req0_shamt;
  assign lr    = gnt1 ? bus.req1_lr    : bus.req0_lr;
  assign al    = gnt1 ? bus.req1_al    : bus.req0_al;

  always_comb begin
    shres = din;
    unique case (1'b1)
      lr:        shres = din << shamt;
      !lr && al: shres = $signed(din) >>> shamt;
      !lr && !al: shres = din >> shamt;
      default:   shres = din;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      dout_q     <= 8'h00;
      id_q       <= 1'b0;
      last_grant <= !PRIO_RESET;
    end else begin
      if (acc) begin
        state      <= FULL;
        dout_q     <= shres;
        id_q       <= acc1;
        last_grant <= acc1;
      end else if (bus.rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_dout  = dout_q;
  assign bus.rsp_id    = id_q;

`ifdef SHIFT_ARB_CNT_EN
  logic [7:0] cnt0, cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= 8'h00;
      cnt1 <= 8'h00;
    end else begin
      if (acc0 && cnt0 != 8'hff)
        cnt0 <= cnt0 + 8'd1;
      if (acc1 && cnt1 != 8'hff)
        cnt1 <= cnt1 + 8'd1;
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`else
  assign grant_cnt0 = 8'h00;
  assign grant_cnt1 = 8'h00;
`endif

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit barrel shifter. Each requester submits {data, shift amount, direction, arithmetic/logical} through a valid/ready handshake. The block grants one request per cycle, drives the shared shifter, and holds the result in a one-entry output register with its own valid/ready handshake. It sits between the datapath clients and the single shifter instance, so the shifter never needs duplicating.

## Interface
- PRIO_RESET, default 0: requester index (0 or 1) that wins the first contested grant after reset.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_din  input  8  requester 0 operand.
- req0_shamt  input  3  requester 0 shift amount, 0..7.
- req0_lr  input  1  1 = left, 0 = right.
- req0_al  input  1  1 = arithmetic, 0 = logical; ignored when lr=1.
- req1_valid, req1_ready, req1_din, req1_shamt, req1_lr, req1_al: same as the requester 0 ports, for requester 1.
- rsp_valid  output  1  rsp_dout/rsp_id hold a result.
- rsp_ready  input  1  consumer takes the result.
- rsp_dout  output  8  shifted result.
- rsp_id  output  1  index of the requester that owns the result.
- grant_cnt0  output  8  count of accepted requester 0 requests (see Configuration).
- grant_cnt1  output  8  count of accepted requester 1 requests (see Configuration).

## Operation
- The block instantiates one barrel shifter, driven by the granted requester's fields through a 2:1 mux.
- Shifter function:
  - lr=1: logical left shift, zero fill.
  - lr=0, al=1: arithmetic right shift, sign fill from din[7].
  - lr=0, al=0: logical right shift, zero fill.
  - shamt=0: dout = din.
- Output state machine, 1 bit:
  - EMPTY (rsp_valid=0) -> FULL when a request is accepted.
  - FULL -> EMPTY when rsp_ready=1 and no request is accepted that cycle.
  - FULL -> FULL when rsp_ready=1 and a request is accepted the same cycle (drain and refill).
  - FULL with rsp_ready=0: hold rsp_dout/rsp_id unchanged; no request is accepted.
- Slot free: state==EMPTY or rsp_ready=1.
- Arbitration uses a last_grant register.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - last_grant updates only on acceptance.
- reqN_ready = granted_N & slot_free & !rst. Ready is combinational from the valids, last_grant, state and rsp_ready.
- At most one ready is high per cycle. A request is accepted when reqN_valid & reqN_ready.
- Requesters keep their fields stable while valid and not ready. The block does not register request fields before acceptance.
- Reset, including mid-operation:
  - rsp_valid=0, rsp_dout=0x00, rsp_id=0.
  - last_grant = 1-PRIO_RESET.
  - Counters = 0.
  - A result pending at reset is discarded. No request is accepted in a cycle where rst=1.

## Timing
- Latency: a request accepted at edge n appears on rsp_dout, with rsp_valid=1, after edge n. One cycle.
- Throughput: 1 result per cycle while rsp_ready is held at 1.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate every cycle. Worst-case wait for a requester is 1 grant.
- rsp_dout, rsp_id and rsp_valid are registered. reqN_ready is combinational.

## Configuration
- SHIFT_ARB_CNT_EN defined:
  - grant_cnt0 and grant_cnt1 increment by 1 on each acceptance by the corresponding requester.
  - Both saturate at 255 and reset to 0.
- SHIFT_ARB_CNT_EN undefined:
  - The ports remain, tied to constant 0x00.
  - No counter flops are synthesized.

## Test plan
- Single request: req0 {din=0xB4, shamt=2, lr=0, al=1}, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_dout=0xED, rsp_id=0.
- Function sweep on req1: {0x81,1,lr=1} -> 0x02; {0x80,7,lr=0,al=0} -> 0x01; {0x80,7,lr=0,al=1} -> 0xFF; {0x5A,0,lr=0,al=1} -> 0x5A. All with rsp_id=1.
- Contention with PRIO_RESET=0: both valid continuously for 6 cycles after reset, rsp_ready=1 -> grant order 0,1,0,1,0,1; 6 results back-to-back. With SHIFT_ARB_CNT_EN defined, grant_cnt0=3 and grant_cnt1=3.
- Backpressure: rsp_ready=0 for 4 cycles with a result held -> rsp_dout/rsp_id stable and both reqN_ready=0. Raising rsp_ready with req0 valid -> drain and new acceptance in the same cycle; rsp_valid stays 1.
- Reset mid-operation: assert rst for 1 cycle while FULL and both valid -> rsp_valid=0, rsp_dout=0x00, both ready=0 during reset. The first post-reset contested grant goes to PRIO_RESET.
- Counter saturation (macro defined): 300 accepted req0 requests -> grant_cnt0=255 and stays 255. Without the macro, both counters read 0x00 throughout.
